// File: rtl/cv32e40px_hwloop_sequencer.sv
// Hardware-loop sequencer: detects loop-end retirement, strobes counter decrements
// and requests fetch redirects; shared-end nested loops are serialised through DEC2.
module cv32e40px_hwloop_sequencer #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_retire_i,
  input  logic [31:0]                pc_id_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_counter_i,
  input  logic                       hwlp_cnt_we_i,
  input  logic [N_REG_BITS-1:0]      hwlp_regid_i,
  input  logic                       flush_i,
  input  logic                       jump_ack_i,
  output logic [N_REGS-1:0]          hwlp_dec_cnt_o,
  output logic                       hwlp_dec_valid_o,
  output logic                       jump_req_o,
  output logic [31:0]                jump_target_o,
  output logic                       stall_id_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC2 = 2'd1,
    JUMP = 2'd2
  } state_e;

  localparam logic [N_REGS-1:0] ONE = {{(N_REGS-1){1'b0}}, 1'b1};

  function automatic logic [N_REG_BITS-1:0] oh2idx(input logic [N_REGS-1:0] oh);
    logic [N_REG_BITS-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REGS; k++) begin
      idx = idx | (oh[k] ? N_REG_BITS'(k) : {N_REG_BITS{1'b0}});
    end
    return idx;
  endfunction

  state_e                  state_r;
  logic [N_REG_BITS-1:0]   sec_idx_r;
  logic                    sec_cont_r;
  logic [31:0]             jump_target_r;
  logic                    jump_req_r;
  logic                    stall_r;
  logic                    busy_r;

  logic [N_REGS-1:0]       match_s;
  logic [N_REGS-1:0]       exit_s;
  logic [N_REGS-1:0]       rest_s;
  logic [N_REGS-1:0]       p_oh_s;
  logic [N_REGS-1:0]       s_oh_s;
  logic [N_REG_BITS-1:0]   p_idx_s;
  logic [N_REG_BITS-1:0]   s_idx_s;
  logic                    p_found_s;
  logic                    s_found_s;
  logic                    p_exit_s;
  logic                    s_exit_s;
  logic [N_REGS-1:0]       sec_oh_s;
  logic [N_REGS-1:0]       dec_s;

  // Per-loop end-address match and exit classification.
  always_comb begin
    match_s = '0;
    exit_s  = '0;
    for (int k = 0; k < N_REGS; k++) begin
      match_s[k] = instr_retire_i && (pc_id_i == (hwlp_end_addr_i[k] - 32'd4)) &&
                   (hwlp_counter_i[k] != 32'd0);
      exit_s[k]  = (hwlp_counter_i[k] == 32'd1);
    end
  end

  // Lowest set bit isolates primary loop; the remainder yields the secondary.
  always_comb begin
    p_oh_s    = match_s & (~match_s + ONE);
    rest_s    = match_s & ~p_oh_s;
    s_oh_s    = rest_s & (~rest_s + ONE);
    p_idx_s   = oh2idx(p_oh_s);
    s_idx_s   = oh2idx(s_oh_s);
    p_found_s = |match_s;
    s_found_s = |rest_s;
    p_exit_s  = |(p_oh_s & exit_s);
    s_exit_s  = |(s_oh_s & exit_s);
    sec_oh_s  = ONE << sec_idx_r;
  end

  // Decrement strobe; a concurrent counter write to the same loop wins.
  always_comb begin
    dec_s = '0;
    case (state_r)
      IDLE: dec_s = (hwlp_cnt_we_i && (hwlp_regid_i == p_idx_s)) ? '0 : p_oh_s;
      DEC2: dec_s = (flush_i || (hwlp_cnt_we_i && (hwlp_regid_i == sec_idx_r))) ? '0 : sec_oh_s;
      default: dec_s = '0;
    endcase
  end

  // Sequencer state machine with registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      sec_idx_r     <= '0;
      sec_cont_r    <= 1'b0;
      jump_target_r <= 32'd0;
      jump_req_r    <= 1'b0;
      stall_r       <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (p_found_s && !p_exit_s) begin
            state_r       <= JUMP;
            jump_target_r <= hwlp_start_addr_i[p_idx_s];
            jump_req_r    <= 1'b1;
            stall_r       <= 1'b1;
            busy_r        <= 1'b1;
          end else if (p_found_s && s_found_s) begin
            state_r    <= DEC2;
            sec_idx_r  <= s_idx_s;
            sec_cont_r <= !s_exit_s;
            jump_req_r <= 1'b0;
            stall_r    <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            jump_req_r <= 1'b0;
            stall_r    <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        DEC2: begin
          if (!flush_i && sec_cont_r) begin
            state_r       <= JUMP;
            jump_target_r <= hwlp_start_addr_i[sec_idx_r];
            jump_req_r    <= 1'b1;
            stall_r       <= 1'b1;
            busy_r        <= 1'b1;
          end else begin
            state_r    <= IDLE;
            jump_req_r <= 1'b0;
            stall_r    <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        JUMP: begin
          if (flush_i || jump_ack_i) begin
            state_r    <= IDLE;
            jump_req_r <= 1'b0;
            stall_r    <= 1'b0;
            busy_r     <= 1'b0;
          end else begin
            state_r    <= JUMP;
            jump_req_r <= 1'b1;
            stall_r    <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          jump_req_r <= 1'b0;
          stall_r    <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign hwlp_dec_cnt_o   = dec_s;
  assign hwlp_dec_valid_o = |dec_s;
  assign jump_req_o       = jump_req_r;
  assign jump_target_o    = jump_target_r;
  assign stall_id_o       = stall_r;
  assign busy_o           = busy_r;

endmodule

// File: tb/tb_cv32e40px_hwloop_sequencer.sv
// Directed self-checking bench for the hardware-loop sequencer.
module tb_cv32e40px_hwloop_sequencer;

  logic              clk;
  logic              rst_n;
  logic              instr_retire_i;
  logic [31:0]       pc_id_i;
  logic [1:0][31:0]  hwlp_start_addr_i;
  logic [1:0][31:0]  hwlp_end_addr_i;
  logic [1:0][31:0]  hwlp_counter_i;
  logic              hwlp_cnt_we_i;
  logic [0:0]        hwlp_regid_i;
  logic              flush_i;
  logic              jump_ack_i;
  logic [1:0]        hwlp_dec_cnt_o;
  logic              hwlp_dec_valid_o;
  logic              jump_req_o;
  logic [31:0]       jump_target_o;
  logic              stall_id_o;
  logic              busy_o;

  int checks;
  int errors;

  cv32e40px_hwloop_sequencer #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_retire_i    (instr_retire_i),
    .pc_id_i           (pc_id_i),
    .hwlp_start_addr_i (hwlp_start_addr_i),
    .hwlp_end_addr_i   (hwlp_end_addr_i),
    .hwlp_counter_i    (hwlp_counter_i),
    .hwlp_cnt_we_i     (hwlp_cnt_we_i),
    .hwlp_regid_i      (hwlp_regid_i),
    .flush_i           (flush_i),
    .jump_ack_i        (jump_ack_i),
    .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
    .hwlp_dec_valid_o  (hwlp_dec_valid_o),
    .jump_req_o        (jump_req_o),
    .jump_target_o     (jump_target_o),
    .stall_id_o        (stall_id_o),
    .busy_o            (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] dec, input logic valid,
                           input logic req, input logic stall, input logic busy);
    check({tag, ".dec"},   {30'd0, hwlp_dec_cnt_o}, {30'd0, dec});
    check({tag, ".valid"}, {31'd0, hwlp_dec_valid_o}, {31'd0, valid});
    check({tag, ".req"},   {31'd0, jump_req_o}, {31'd0, req});
    check({tag, ".stall"}, {31'd0, stall_id_o}, {31'd0, stall});
    check({tag, ".busy"},  {31'd0, busy_o}, {31'd0, busy});
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    instr_retire_i = 1'b0;
    pc_id_i = 32'd0;
    hwlp_start_addr_i = '0;
    hwlp_end_addr_i = '0;
    hwlp_counter_i = '0;
    hwlp_cnt_we_i = 1'b0;
    hwlp_regid_i = 1'b0;
    flush_i = 1'b0;
    jump_ack_i = 1'b0;

    tick(); #2;
    check_out("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.target", jump_target_o, 32'h0);
    tick();
    rst_n = 1'b1;

    // Single loop, counter 3: continue with redirect held until ack.
    hwlp_start_addr_i[0] = 32'h100; hwlp_end_addr_i[0] = 32'h120;
    hwlp_start_addr_i[1] = 32'h200; hwlp_end_addr_i[1] = 32'h240;
    hwlp_counter_i[0] = 32'd3;
    instr_retire_i = 1'b1; pc_id_i = 32'h118; #2;
    check_out("nomatch_pc", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    pc_id_i = 32'h11C; #1;
    check_out("c3.match", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; #2;
    check_out("c3.jump", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("c3.target", jump_target_o, 32'h100);
    tick(); #2;
    check_out("c3.hold", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("c3.target_hold", jump_target_o, 32'h100);
    jump_ack_i = 1'b1;
    tick(); jump_ack_i = 1'b0; #2;
    check_out("c3.acked", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Counter 2: continue again.
    hwlp_counter_i[0] = 32'd2; instr_retire_i = 1'b1; #2;
    check_out("c2.match", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; jump_ack_i = 1'b1; #2;
    check_out("c2.jump", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(); jump_ack_i = 1'b0; #2;
    check_out("c2.acked", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Counter 1: exit, no redirect.
    hwlp_counter_i[0] = 32'd1; instr_retire_i = 1'b1; #2;
    check_out("c1.match", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; #2;
    check_out("c1.after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Nested loops sharing end 0x240: inner exits, outer continues.
    hwlp_end_addr_i[0] = 32'h240;
    hwlp_counter_i[0] = 32'd1; hwlp_counter_i[1] = 32'd5;
    instr_retire_i = 1'b1; pc_id_i = 32'h23C; #2;
    check_out("nest.c0", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; #2;
    check_out("nest.c1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); #2;
    check_out("nest.c2", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("nest.target", jump_target_o, 32'h200);
    jump_ack_i = 1'b1;
    tick(); jump_ack_i = 1'b0; #2;
    check_out("nest.acked", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both loops exit on the shared end.
    hwlp_counter_i[1] = 32'd1;
    instr_retire_i = 1'b1; #2;
    check_out("bx.c0", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; #2;
    check_out("bx.c1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); #2;
    check_out("bx.c2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Counter write collision suppresses the strobe but not the jump.
    hwlp_end_addr_i[0] = 32'h120;
    hwlp_counter_i[0] = 32'd4; hwlp_counter_i[1] = 32'd0;
    instr_retire_i = 1'b1; pc_id_i = 32'h11C;
    hwlp_cnt_we_i = 1'b1; hwlp_regid_i = 1'b0; #2;
    check_out("coll.match", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; hwlp_cnt_we_i = 1'b0; #2;
    check_out("coll.jump", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("coll.target", jump_target_o, 32'h100);
    jump_ack_i = 1'b1;
    tick(); jump_ack_i = 1'b0; #2;
    check_out("coll.acked", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush while waiting for ack.
    hwlp_counter_i[0] = 32'd3; instr_retire_i = 1'b1; #2;
    check_out("fl.match", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_out("fl.wait", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
    end
    flush_i = 1'b1; #2;
    check_out("fl.flush", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(); flush_i = 1'b0; #2;
    check_out("fl.after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of DEC2.
    hwlp_end_addr_i[0] = 32'h240;
    hwlp_counter_i[0] = 32'd1; hwlp_counter_i[1] = 32'd5;
    instr_retire_i = 1'b1; pc_id_i = 32'h23C;
    tick(); instr_retire_i = 1'b0; #2;
    check_out("rst.dec2", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0; #1;
    check_out("rst.async", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.target", jump_target_o, 32'h0);
    tick(); rst_n = 1'b1;

    // Inactive loops never match.
    hwlp_counter_i[0] = 32'd0; hwlp_counter_i[1] = 32'd0;
    instr_retire_i = 1'b1; pc_id_i = 32'h23C; #2;
    check_out("cnt0.match", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); instr_retire_i = 1'b0; #2;
    check_out("cnt0.after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40px_hwloop_sequencer.md
Name: cv32e40px_hwloop_sequencer

Overview:
- Sequences the hardware-loop register file.
- Watches each instruction retiring from ID. It detects the last instruction of an active loop, requests a fetch redirect to the loop start, and issues counter-decrement strobes to the hwloop register file.
- Guarantees at most one decrement per cycle. Nested loops that share an end address are serialised with a one-cycle ID stall.
- Sits between the ID stage, the hwloop register file and the prefetch/fetch unit.

Parameters:
N_REGS, 2, number of hardware loops; index 0 is the innermost loop and has the highest priority.
N_REG_BITS, $clog2(N_REGS), width of the loop index.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
instr_retire_i  input  1  instruction in ID completes this cycle (valid and ID ready)
pc_id_i  input  32  PC of the retiring instruction
hwlp_start_addr_i  input  N_REGS x 32  loop start addresses
hwlp_end_addr_i  input  N_REGS x 32  loop end addresses (address following the last loop instruction)
hwlp_counter_i  input  N_REGS x 32  current loop counters
hwlp_cnt_we_i  input  1  counter write in progress this cycle
hwlp_regid_i  input  N_REG_BITS  target loop of the counter write
flush_i  input  1  branch, exception or debug flush
jump_ack_i  input  1  fetch accepted the redirect
hwlp_dec_cnt_o  output  N_REGS  one-hot decrement strobe
hwlp_dec_valid_o  output  1  qualifies hwlp_dec_cnt_o; drives the register file valid input
jump_req_o  output  1  redirect request to fetch
jump_target_o  output  32  redirect address
stall_id_o  output  1  blocks further ID retirement
busy_o  output  1  state machine not in IDLE

Behaviour:
- Reset is rst_n: asynchronous, active-low. Clock is clk.
- At reset: state IDLE, all outputs 0, jump_target_o = 0.
- Loop k matches when all of the following hold:
  - instr_retire_i = 1
  - pc_id_i == hwlp_end_addr_i[k] - 4 (32-bit wrap-around subtraction)
  - hwlp_counter_i[k] != 0
- A counter value of 0 means the loop is inactive. Matching is evaluated only in IDLE.
- Classification of a matching loop (counter compared as unsigned):
  - counter >= 2: "continue".
  - counter == 1: "exit". The loop is decremented but no jump is taken.
- Primary loop p is the lowest-index matching loop.
- Secondary loop s is the lowest index > p that matches; it is considered only if p is an exit.
- IDLE, on a match of p, in the same cycle:
  - hwlp_dec_cnt_o = onehot(p) and hwlp_dec_valid_o = 1.
  - Exception: the strobe for p is suppressed if hwlp_cnt_we_i = 1 and hwlp_regid_i == p; the register write has priority.
- IDLE next-state:
  - p continue -> JUMP, with jump_target_o registered as start[p].
  - p exit and s is a continue -> DEC2, with s registered.
  - p exit and s is an exit -> DEC2, with s registered; the jump is suppressed.
  - p exit and no s -> stay IDLE (fall-through).
- DEC2, exactly one cycle:
  - Drives dec = onehot(s), valid = 1 (same suppression rule applies) and stall_id_o = 1.
  - If s is a continue: -> JUMP with target start[s]. Otherwise -> IDLE.
  - Only one secondary level is handled; further levels sharing the same end address are undefined.
- JUMP:
  - jump_req_o = 1 and stall_id_o = 1. jump_target_o stays stable until acknowledged.
  - jump_ack_i = 1 -> IDLE, with jump_req_o low in the following cycle.
- flush_i:
  - In JUMP or DEC2: -> IDLE next cycle, no further strobes. Decrements already issued are not undone.
  - In IDLE: the match is still evaluated (the retiring instruction committed).
- Only one strobe bit is ever set per cycle.
- busy_o = (state != IDLE).
- Outputs other than the decrement strobes are registered or state-decoded; the strobes are combinational in IDLE.

Test Plan:
- Loop 0: start 0x100, end 0x120, cnt 3. Retire PC 0x11C -> dec 01 pulse, jump_req with target 0x100 held until ack; repeat: cnt 2 -> jump again; cnt 1 -> dec 01, no jump, state stays IDLE.
- Nested shared end: loop0 cnt 1, loop1 cnt 5, start1 0x200, both end 0x240. Retire 0x23C -> cycle 0 dec 01; cycle 1 dec 10 with stall_id_o = 1; cycle 2 jump_req to 0x200.
- Both loops exit (cnt 1, 1), shared end -> dec 01 then dec 10, no jump_req, back in IDLE after 2 cycles.
- Counter write collision: retire at end of loop0 (cnt 4) with hwlp_cnt_we_i = 1, regid 0 -> no dec strobe, jump still issued to start0.
- Flush in JUMP: hold jump_ack_i = 0 for 3 cycles, then flush_i = 1 -> jump_req_o = 0 next cycle, busy_o = 0, no extra dec.
- Async reset asserted mid-DEC2 -> all outputs 0 immediately; after release, cnt 0 loops never match even with PC equal to end-4.
